// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, operation classes, sequencer state and ALU drive payload.
package alu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEL_W  = 4;

    // ALU select encoding; sel[3:2] is the operation class
    localparam logic [SEL_W-1:0] ALU_INC = 4'h0;
    localparam logic [SEL_W-1:0] ALU_ADD = 4'h1;
    localparam logic [SEL_W-1:0] ALU_SUB = 4'h2;
    localparam logic [SEL_W-1:0] ALU_DEC = 4'h3;
    localparam logic [SEL_W-1:0] ALU_AND = 4'h4;
    localparam logic [SEL_W-1:0] ALU_OR  = 4'h5;
    localparam logic [SEL_W-1:0] ALU_XOR = 4'h6;
    localparam logic [SEL_W-1:0] ALU_NOT = 4'h7;
    localparam logic [SEL_W-1:0] ALU_SHR = 4'h8;
    localparam logic [SEL_W-1:0] ALU_SHL = 4'hC;

    typedef enum logic [1:0] {
        ARITH = 2'd0,
        LOGIC = 2'd1,
        SHR   = 2'd2,
        SHL   = 2'd3
    } op_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One word's worth of ALU drive
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic              cin;
        logic [SEL_W-1:0]  sel;
    } alu_drive_t;

    function automatic op_class_t op_class(input logic [SEL_W-1:0] sel);
        return op_class_t'(sel[3:2]);
    endfunction

endpackage

// File: rtl/alu_wide_sequencer_if.sv
// Request/response channels plus the 32-bit ALU port of the wide sequencer.
interface alu_wide_sequencer_if #(
    parameter int unsigned WORDS = 2
);
    import alu_pkg::*;

    localparam int unsigned DW = WORD_W * WORDS;

    logic              req_valid;
    logic              req_ready;
    logic [SEL_W-1:0]  req_op;
    logic [DW-1:0]     req_a;
    logic [DW-1:0]     req_b;
    logic              req_cin;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_f;
    logic              rsp_cout;

    logic [WORD_W-1:0] alu_a;
    logic [WORD_W-1:0] alu_b;
    logic              alu_cin;
    logic [SEL_W-1:0]  alu_sel;
    logic [WORD_W-1:0] alu_f;
    logic              alu_cout;

    // Sequencer side
    modport master (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready, alu_f, alu_cout,
        output req_ready, rsp_valid, rsp_f, rsp_cout, alu_a, alu_b, alu_cin, alu_sel
    );

    // Requester / ALU side
    modport slave (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready, alu_f, alu_cout,
        input  req_ready, rsp_valid, rsp_f, rsp_cout, alu_a, alu_b, alu_cin, alu_sel
    );

endinterface

// File: rtl/alu_wide_sequencer.sv
// Runs a 32*WORDS-bit operation through an external 32-bit ALU one word per cycle,
// chaining carry/borrow or shifted-out bits between words.
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_wide_sequencer_if.master bus
);

    localparam int unsigned DW = WORD_W * WORDS;
    localparam int unsigned CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    if (WORDS == 0) begin : g_words_check
        $error("alu_wide_sequencer: WORDS must be >= 1");
    end

    state_t           state_q, state_d;
    logic [SEL_W-1:0] op_q, op_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d, f_q, f_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             chain_q, chain_d;
    logic             cout_q, cout_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_ready_q;
    alu_drive_t       drv_q, drv_d;

    op_class_t         cls;
    logic [CW-1:0]     w_cur, w_nxt, w_first;
    logic [WORD_W-1:0] r;
    logic              c_nxt;

    // Shift-right walks MSW->LSW, everything else LSW->MSW
    function automatic logic [CW-1:0] word_index(input logic [CW-1:0] cnt, input op_class_t c);
        return (c == SHR) ? CW'(LAST - cnt) : cnt;
    endfunction

    assign cls = op_class(op_q);

    // Next state, word result and ALU drive for the following cycle
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        f_d         = f_q;
        cnt_d       = cnt_q;
        chain_d     = chain_q;
        cout_d      = cout_q;
        rsp_valid_d = rsp_valid_q;
        drv_d       = '0;
        w_first     = '0;
        w_cur       = word_index(cnt_q, cls);
        w_nxt       = word_index(CW'(cnt_q + 1'b1), cls);

        case (cls)
            ARITH:   begin r = bus.alu_f;                                c_nxt = bus.alu_cout; end
            LOGIC:   begin r = bus.alu_f;                                c_nxt = 1'b0;         end
            SHR:     begin r = bus.alu_f | {chain_q, (WORD_W-1)'(0)};    c_nxt = bus.alu_cout; end
            SHL:     begin r = bus.alu_f | {(WORD_W-1)'(0), chain_q};    c_nxt = bus.alu_cout; end
            default: begin r = bus.alu_f;                                c_nxt = 1'b0;         end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d      = bus.req_op;
                    a_d       = bus.req_a;
                    b_d       = bus.req_b;
                    cnt_d     = '0;
                    chain_d   = (op_class(bus.req_op) == ARITH) ? bus.req_cin : 1'b0;
                    w_first   = (op_class(bus.req_op) == SHR) ? LAST : '0;
                    drv_d.a   = bus.req_a[WORD_W*w_first +: WORD_W];
                    drv_d.b   = bus.req_b[WORD_W*w_first +: WORD_W];
                    drv_d.cin = (op_class(bus.req_op) == ARITH) ? bus.req_cin : 1'b0;
                    drv_d.sel = bus.req_op;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                f_d[WORD_W*w_cur +: WORD_W] = r;
                chain_d = c_nxt;
                if (cnt_q == LAST) begin
                    cout_d      = c_nxt;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d     = CW'(cnt_q + 1'b1);
                    drv_d.a   = a_q[WORD_W*w_nxt +: WORD_W];
                    drv_d.b   = b_q[WORD_W*w_nxt +: WORD_W];
                    drv_d.cin = (cls == ARITH) ? c_nxt : 1'b0;
                    drv_d.sel = op_q;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Operand, result, handshake and ALU drive registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            cnt_q       <= '0;
            chain_q     <= 1'b0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            drv_q       <= '0;
        end else begin
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f_q         <= f_d;
            cnt_q       <= cnt_d;
            chain_q     <= chain_d;
            cout_q      <= cout_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= (state_d == ST_IDLE);
            drv_q       <= drv_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_f     = f_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.alu_a     = drv_q.a;
    assign bus.alu_b     = drv_q.b;
    assign bus.alu_cin   = drv_q.cin;
    assign bus.alu_sel   = drv_q.sel;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer (WORDS=2) paired with a behavioural 32-bit ALU.
module tb_alu_wide_sequencer;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] f;
        logic        cout;
    } vec_t;

    localparam int NVEC = 14;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_accept = 0;
    int   last_hs     = 0;
    vec_t vecs[NVEC];
    logic [31:0] addend;
    logic [32:0] sum;

    alu_wide_sequencer_if #(.WORDS(2)) bus ();

    alu_wide_sequencer #(.WORDS(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 32-bit ALU
    always_comb begin
        addend       = 32'h0;
        sum          = 33'h0;
        bus.alu_f    = 32'h0;
        bus.alu_cout = 1'b0;
        case (bus.alu_sel[3:2])
            2'b00: begin
                case (bus.alu_sel[1:0])
                    2'b00:   addend = 32'h0;
                    2'b01:   addend = bus.alu_b;
                    2'b10:   addend = ~bus.alu_b;
                    default: addend = 32'hFFFF_FFFF;
                endcase
                sum          = {1'b0, bus.alu_a} + {1'b0, addend} + {32'h0, bus.alu_cin};
                bus.alu_f    = sum[31:0];
                bus.alu_cout = sum[32];
            end
            2'b01: begin
                case (bus.alu_sel[1:0])
                    2'b00:   bus.alu_f = bus.alu_a & bus.alu_b;
                    2'b01:   bus.alu_f = bus.alu_a | bus.alu_b;
                    2'b10:   bus.alu_f = bus.alu_a ^ bus.alu_b;
                    default: bus.alu_f = ~bus.alu_a;
                endcase
            end
            2'b10: begin
                bus.alu_f    = bus.alu_a >> 1;
                bus.alu_cout = bus.alu_a[0];
            end
            default: begin
                bus.alu_f    = bus.alu_a << 1;
                bus.alu_cout = bus.alu_a[31];
            end
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic [63:0] f, input logic cout);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = cin; v.f = f; v.cout = cout;
        return v;
    endfunction

    // Present a request and return just after the accept edge
    task automatic send(input vec_t v, input string tag);
        int w;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_cin   = v.cin;
        @(posedge clk);
        last_accept = cyc + 1;
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Full transaction: latency, first-word ALU drive, result, optional stall, handshake
    task automatic run_vec(input vec_t v, input string tag, input int stall);
        int lat;
        logic [31:0] first_a;
        send(v, tag);
        first_a = (v.op[3:2] == 2'b10) ? v.a[63:32] : v.a[31:0];
        check({tag, "_alu_sel"}, 64'(bus.alu_sel), 64'(v.op));
        check({tag, "_alu_a"}, 64'(bus.alu_a), 64'(first_a));
        check({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        check({tag, "_latency"}, 64'(lat), 64'd2);
        check({tag, "_f"}, bus.rsp_f, v.f);
        check({tag, "_cout"}, 64'(bus.rsp_cout), 64'(v.cout));
        check({tag, "_alu_idle"}, {bus.alu_a, bus.alu_sel, 28'h0}, 64'h0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold"}, {bus.rsp_f[62:0], bus.rsp_cout},
                  {v.f[62:0], v.cout});
            check({tag, "_hold_hs"}, {62'h0, bus.rsp_valid, bus.req_ready}, 64'd2);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        last_hs = cyc + 1;
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_hs"}, {62'h0, bus.rsp_valid, bus.req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_hs;

        vecs[0]  = mk(4'h1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
        vecs[1]  = mk(4'h2, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vecs[2]  = mk(4'h3, 64'h0000_0001_0000_0000, 64'h0, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1);
        vecs[3]  = mk(4'h8, 64'h0000_0001_0000_0001, 64'h0, 1'b0, 64'h0000_0000_8000_0000, 1'b1);
        vecs[4]  = mk(4'hC, 64'h8000_0000_8000_0000, 64'h0, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        vecs[5]  = mk(4'h6, 64'hFFFF_0000_1234_5678, 64'h0F0F_0F0F_FFFF_FFFF, 1'b1,
                      64'hF0F0_0F0F_EDCB_A987, 1'b0);
        vecs[6]  = mk(4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
        vecs[7]  = mk(4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
        vecs[8]  = mk(4'h0, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 1'b0);
        vecs[9]  = mk(4'h4, 64'hF0F0_F0F0_1234_5678, 64'hFF00_FF00_0000_FFFF, 1'b0,
                      64'hF000_F000_0000_5678, 1'b0);
        vecs[10] = mk(4'h7, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0);
        vecs[11] = mk(4'h8, 64'h8000_0000_0000_0000, 64'h0, 1'b0, 64'h4000_0000_0000_0000, 1'b0);
        vecs[12] = mk(4'hC, 64'h0000_0001_FFFF_FFFF, 64'h0, 1'b0, 64'h0000_0003_FFFF_FFFE, 1'b0);
        vecs[13] = mk(4'h2, 64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1);

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_a     = 64'h0;
        bus.req_b     = 64'h0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(bus.req_ready), 64'd1);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_f", bus.rsp_f, 64'h0);
        check("reset_rsp_cout", 64'(bus.rsp_cout), 64'd0);
        check("reset_alu_drive", {bus.alu_a, bus.alu_b[27:0], bus.alu_sel},
              64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            run_vec(vecs[i], $sformatf("vec%0d", i), 0);
        end

        // Long response stall, then back-to-back request right after the handshake
        @(negedge clk);
        run_vec(vecs[0], "stall", 10);
        prev_hs = last_hs;
        run_vec(vecs[1], "b2b", 0);
        check("b2b_accept_gap", 64'(last_accept - prev_hs), 64'd1);

        // Reset during the first EXEC cycle discards the operation
        @(negedge clk);
        send(vecs[4], "rst");
        rst_n = 1'b0;
        #1;
        check("rst_async", {61'h0, bus.rsp_valid, bus.req_ready, |bus.alu_sel}, 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("rst_quiet", {62'h0, bus.rsp_valid, bus.req_ready}, 64'd1);
        end
        @(negedge clk);
        run_vec(vecs[0], "post_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
